dmem_access_ctrl: RTL
=====================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, word-address width (32 words).
REQ-002 Parameter DATA_W, default 32, memory word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 {a,b}_req_valid  in  1  requester has a pending access.
REQ-006 {a,b}_req_ready  out  1  request accepted this cycle when valid && ready.
REQ-007 {a,b}_addr  in  ADDR_W  word address.
REQ-008 {a,b}_we  in  1  1 = store, 0 = load.
REQ-009 {a,b}_size  in  2  00 word, 01 halfword [15:0], 10 byte [7:0], 11 illegal.
REQ-010 {a,b}_wdata  in  DATA_W  store data, low bits used for sub-word.
REQ-011 {a,b}_resp_valid  out  1  one-cycle completion pulse.
REQ-012 {a,b}_resp_err  out  1  qualifies resp_valid; 1 = illegal size.
REQ-013 {a,b}_rdata  out  DATA_W  load data, zero-extended; 0 for stores and errors.
REQ-014 mem_addr  out  ADDR_W  memory word address.
REQ-015 mem_re  out  1  memory read strobe; mem_rdata valid next cycle.
REQ-016 mem_we  out  1  full-word write strobe, written on that clock edge.
REQ-017 mem_wdata  out  DATA_W  full-word write data.
REQ-018 mem_rdata  in  DATA_W  read data, one cycle after mem_re.
REQ-019 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-020 FSM states IDLE, RD, RD_WAIT, WR, RESP; requests are accepted only in IDLE.
REQ-021 In IDLE, a single valid requester is granted; with both valid, the requester not granted last wins (round-robin).
REQ-022 req_ready is combinational, high only for the granted requester in IDLE; the accepted addr/we/size/wdata/owner are registered.
REQ-023 Load: IDLE -> RD (mem_re=1) -> RD_WAIT (capture mem_rdata) -> RESP; resp_valid exactly 3 cycles after accept.
REQ-024 Load byte returns {24'b0, word[7:0]}; load halfword returns {16'b0, word[15:0]}; load word returns the word unmodified.
REQ-025 Word store: IDLE -> WR (mem_we=1, mem_wdata=wdata) -> RESP; resp_valid 2 cycles after accept.
REQ-026 Sub-word store: IDLE -> RD -> RD_WAIT -> WR -> RESP, read-modify-write; resp_valid 4 cycles after accept.
REQ-027 Merge rules: byte store writes {old[31:8], wdata[7:0]}; halfword store writes {old[31:16], wdata[15:0]}.
REQ-028 Size 11: IDLE -> RESP with resp_err=1 and rdata=0; mem_re and mem_we stay 0.
REQ-029 resp_valid, resp_err and rdata are driven only on the owning requester's ports and last one cycle; there is no backpressure.
REQ-030 RESP always returns to IDLE; the next accept occurs no earlier than the cycle after RESP.
REQ-031 mem_re and mem_we are never high in the same cycle; mem_addr holds the registered address from RD through WR.
REQ-032 A requester whose valid drops before ready is ignored; the arbiter pointer updates only on an accept.

Reset
REQ-033 rst_n low immediately forces IDLE; all outputs go to 0 and the last-grant pointer goes to b, so a wins first.
REQ-034 Reset mid-operation drops the in-flight request: no response, and no mem_we after reset assertion.

Structure
REQ-035 Package dmem_pkg holds the size encoding enum, the FSM state enum, ADDR_W and DATA_W defaults.
REQ-036 Sub-module dmem_rr_arb implements the 2-way round-robin grant and its pointer register.

Verification
REQ-037 After reset, a loads word at addr 3 (mem holds 0xDEADBEEF) -> mem_re at accept+1; a_resp_valid at accept+3 with a_rdata=0xDEADBEEF.
REQ-038 b stores byte 0xA5 at addr 7 (old 0x11223344) -> one mem_re, then mem_we with mem_wdata=0x112233A5; b_resp_valid at accept+4.
REQ-039 a and b valid together for 4 consecutive requests -> grants alternate a, b, a, b; no response is lost.
REQ-040 a issues size=11 -> a_resp_err=1, a_rdata=0 at accept+1; mem_re and mem_we never assert.
REQ-041 rst_n pulsed low during WR of a halfword store -> mem_we drops at once, no resp_valid; the next request is served normally.
REQ-042 Load halfword at addr 0 holding 0xCAFEBABE -> rdata=0x0000BABE; load byte returns 0x000000BE.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory access controller.
package dmem_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_RESP
  } state_e;

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin grant; the pointer remembers who was granted last.
module dmem_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_b;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (a_valid && b_valid) begin
        gnt_a = last_b;
        gnt_b = !last_b;
      end else begin
        gnt_a = a_valid;
        gnt_b = b_valid;
      end
    end
  end

  // Reset points at b so that a wins the first contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (gnt_a || gnt_b) begin
      last_b <= gnt_b;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrated load/store front end for a single-port word memory with
// sub-word loads and read-modify-write sub-word stores.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_resp_valid,
  output logic              a_resp_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [1:0]        b_size,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_resp_valid,
  output logic              b_resp_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  size_e             size_q;
  logic              owner_q;
  logic [DATA_W-1:0] data_q;

  logic              idle;
  logic              gnt_a, gnt_b, accept;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  size_e             sel_size;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rd_word;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;

  assign idle = (state == ST_IDLE);

  dmem_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (idle),
    .a_valid (a_req_valid),
    .b_valid (b_req_valid),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  assign a_req_ready = gnt_a;
  assign b_req_ready = gnt_b;
  assign accept      = gnt_a || gnt_b;

  assign sel_addr  = gnt_b ? b_addr  : a_addr;
  assign sel_we    = gnt_b ? b_we    : a_we;
  assign sel_size  = size_e'(gnt_b ? b_size : a_size);
  assign sel_wdata = gnt_b ? b_wdata : a_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (sel_size == SZ_ILL)                      state_nxt = ST_RESP;
          else if (sel_we && (sel_size == SZ_WORD))    state_nxt = ST_WR;
          else                                         state_nxt = ST_RD;
        end
      end
      ST_RD:      state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: state_nxt = we_q ? ST_WR : ST_RESP;
      ST_WR:      state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // data_q holds the store data from accept; in RD_WAIT it becomes either the
  // formatted load result or the merged write word, so one register serves both.
  always_comb begin
    rd_word = '0;
    if (we_q) begin
      case (size_q)
        SZ_HALF: rd_word = {mem_rdata[DATA_W-1:16], data_q[15:0]};
        SZ_BYTE: rd_word = {mem_rdata[DATA_W-1:8], data_q[7:0]};
        default: rd_word = data_q;
      endcase
    end else begin
      case (size_q)
        SZ_HALF: rd_word[15:0] = mem_rdata[15:0];
        SZ_BYTE: rd_word[7:0]  = mem_rdata[7:0];
        default: rd_word       = mem_rdata;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_WORD;
      owner_q <= 1'b0;
      data_q  <= '0;
    end else if (idle && accept) begin
      addr_q  <= sel_addr;
      we_q    <= sel_we;
      size_q  <= sel_size;
      owner_q <= gnt_b;
      data_q  <= sel_wdata;
    end else if (state == ST_RD_WAIT) begin
      data_q  <= rd_word;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_re    = (state == ST_RD);
  assign mem_we    = (state == ST_WR);
  assign mem_wdata = mem_we ? data_q : '0;
  assign busy      = !idle;

  assign resp_err  = (state == ST_RESP) && (size_q == SZ_ILL);
  assign resp_data = ((state == ST_RESP) && !we_q && (size_q != SZ_ILL)) ? data_q : '0;

  assign a_resp_valid = (state == ST_RESP) && !owner_q;
  assign b_resp_valid = (state == ST_RESP) && owner_q;
  assign a_resp_err   = resp_err && !owner_q;
  assign b_resp_err   = resp_err && owner_q;
  assign a_rdata      = owner_q ? '0 : resp_data;
  assign b_rdata      = owner_q ? resp_data : '0;

endmodule
